// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external add/sub ALU between two valid/ready
// requesters with round-robin arbitration and registered operands/results.
`timescale 1ns/1ps
module alu_share_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [1:0]   req0_op,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [N-1:0] resp0_result,
  output logic         resp0_zero,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [N-1:0] resp1_result,
  output logic         resp1_zero,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state, state_next;
  logic         grant, prio;
  logic [N-1:0] op_a, op_b, res;
  logic [1:0]   op_ctl;
  logic         res_zero;
  logic         pick;
  logic         accept;
  logic         resp_ready_sel;
  logic [1:0]   req_op_sel;
  logic [1:0]   op_norm;

  // Contention is resolved by prio; a lone request is taken directly.
  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid) pick = prio;
    else                          pick = req1_valid;
  end

  assign accept         = (state == IDLE) && (req0_valid || req1_valid);
  assign resp_ready_sel = grant ? resp1_ready : resp0_ready;
  assign req_op_sel     = pick ? req1_op : req0_op;
  // Codes 1x are folded onto add so the ALU only ever sees 00 or 01.
  assign op_norm        = {1'b0, (req_op_sel == 2'b01)};

  always_comb begin
    state_next  = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~pick;
          req1_ready = pick;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        resp0_valid = ~grant;
        resp1_valid = grant;
        if (resp_ready_sel) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 1'b0;
      prio     <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_ctl   <= 2'b00;
      res      <= '0;
      res_zero <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            grant  <= pick;
            op_a   <= pick ? req1_a : req0_a;
            op_b   <= pick ? req1_b : req0_b;
            op_ctl <= op_norm;
          end
        end
        EXEC: begin
          res      <= alu_result;
          res_zero <= alu_zero;
        end
        RESP: begin
          // Hand preference to the other requester once this one is served.
          if (resp_ready_sel) prio <= ~grant;
        end
        default: ;
      endcase
    end
  end

  assign alu_a        = op_a;
  assign alu_b        = op_b;
  assign alu_control  = op_ctl;
  assign resp0_result = res;
  assign resp1_result = res;
  assign resp0_zero   = res_zero;
  assign resp1_zero   = res_zero;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized transactions checked against a
// transaction-level model of arbitration order, latency and arithmetic.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
  logic         req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
  logic [1:0]   req0_op, req1_op, alu_control;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic         alu_zero;
  logic         busy;

  int   compared = 0;
  int   mismatched = 0;
  // Model state: requester favoured on the next contention.
  logic next_pref;

  alu_share_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_zero(resp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the attached combinational ALU.
  assign alu_result = (alu_control == 2'b01) ? (alu_a - alu_b) : (alu_a + alu_b);
  assign alu_zero   = (alu_result == '0);

  function automatic logic [N-1:0] modelResult(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic [1:0] op);
    return (op == 2'b01) ? (a - b) : (a + b);
  endfunction

  task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                             input logic [N-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                               input logic [1:0] op0, input logic v1, input logic [N-1:0] a1,
                               input logic [N-1:0] b1, input logic [1:0] op1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
  endtask

  // Runs one transaction from IDLE (entered at posedge+1) back to IDLE.
  task automatic transact(input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                          input logic [1:0] op0, input logic v1, input logic [N-1:0] a1,
                          input logic [N-1:0] b1, input logic [1:0] op1,
                          input int hold, input string tag);
    logic         g;
    logic [N-1:0] exp_res;
    logic [1:0]   exp_valid;
    applyStimulus(v0, a0, b0, op0, v1, a1, b1, op1);
    g         = (v0 && v1) ? next_pref : v1;
    exp_res   = g ? modelResult(a1, b1, op1) : modelResult(a0, b0, op0);
    exp_valid = g ? 2'b10 : 2'b01;
    resp0_ready = (hold == 0) && !g;
    resp1_ready = (hold == 0) && g;

    @(negedge clk);
    checkOutput({tag, " idle busy"}, N'(busy), N'(1'b0));
    checkOutput({tag, " ready pair"}, N'({req1_ready, req0_ready}), N'({g, !g}));
    checkOutput({tag, " idle resp_valid"}, N'({resp1_valid, resp0_valid}), N'(2'b00));

    @(posedge clk); #1;
    if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, " exec busy"}, N'(busy), N'(1'b1));
    checkOutput({tag, " exec resp_valid"}, N'({resp1_valid, resp0_valid}), N'(2'b00));
    checkOutput({tag, " exec ready pair"}, N'({req1_ready, req0_ready}), N'(2'b00));

    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, " resp_valid"}, N'({resp1_valid, resp0_valid}), N'(exp_valid));
    checkOutput({tag, " result"}, g ? resp1_result : resp0_result, exp_res);
    checkOutput({tag, " zero"}, N'(g ? resp1_zero : resp0_zero), N'(exp_res == '0));
    checkOutput({tag, " resp ready pair"}, N'({req1_ready, req0_ready}), N'(2'b00));

    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput({tag, " held resp_valid"}, N'({resp1_valid, resp0_valid}), N'(exp_valid));
      checkOutput({tag, " held result"}, g ? resp1_result : resp0_result, exp_res);
      checkOutput({tag, " held busy"}, N'(busy), N'(1'b1));
      checkOutput({tag, " held ready pair"}, N'({req1_ready, req0_ready}), N'(2'b00));
    end
    if (hold > 0) begin
      if (g) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      #1;
      checkOutput({tag, " no comb resp->req"}, N'({req1_ready, req0_ready}), N'(2'b00));
    end

    @(posedge clk); #1;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    next_pref   = ~g;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] ra0, rb0, ra1, rb1;
    int           pattern;

    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 2'b00);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    next_pref   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", N'(busy), N'(1'b0));
    checkOutput("reset resp_valid", N'({resp1_valid, resp0_valid}), N'(2'b00));
    checkOutput("reset result", resp0_result, '0);
    checkOutput("reset zero", N'(resp1_zero), N'(1'b0));
    checkOutput("reset ready pair", N'({req1_ready, req0_ready}), N'(2'b00));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 4; k++)
      transact(1'b1, N'(k), 32'd1, 2'b00, 1'b1, N'(100 + k), 32'd2, 2'b01, 0, "contend");

    transact(1'b1, 32'd5, 32'd7, 2'b00, 1'b0, '0, '0, 2'b00, 0, "add");
    transact(1'b0, '0, '0, 2'b00, 1'b1, 32'd9, 32'd9, 2'b01, 0, "sub_zero");
    transact(1'b0, '0, '0, 2'b00, 1'b1, 32'd0, 32'd1, 2'b01, 0, "sub_wrap");
    transact(1'b1, 32'h1234, 32'h10, 2'b01, 1'b1, 32'hAA, 32'h55, 2'b00, 5, "backpressure");
    transact(1'b0, '0, '0, 2'b00, 1'b1, 32'hAA, 32'h55, 2'b00, 0, "after_bp");
    transact(1'b1, 32'd3, 32'd4, 2'b10, 1'b0, '0, '0, 2'b00, 0, "op10");
    transact(1'b1, 32'd3, 32'd4, 2'b11, 1'b0, '0, '0, 2'b00, 0, "op11");

    for (int k = 0; k < 24; k++) begin
      pattern = $urandom_range(1, 3);
      ra0 = $urandom;
      rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
      ra1 = $urandom;
      rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
      transact(pattern[0], ra0, rb0, 2'($urandom_range(0, 3)),
               pattern[1], ra1, rb1, 2'($urandom_range(0, 3)),
               $urandom_range(0, 3), "random");
    end

    transact(1'b1, 32'd1, 32'd1, 2'b00, 1'b0, '0, '0, 2'b00, 0, "pre_reset");
    applyStimulus(1'b1, 32'h50, 32'h50, 2'b01, 1'b0, '0, '0, 2'b00);
    resp0_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midreset busy", N'(busy), N'(1'b0));
    checkOutput("midreset resp_valid", N'({resp1_valid, resp0_valid}), N'(2'b00));
    checkOutput("midreset result", resp0_result, '0);
    checkOutput("midreset zero", N'(resp0_zero), N'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    resp0_ready = 1'b0;
    next_pref = 1'b0;
    transact(1'b1, 32'h20, 32'h22, 2'b00, 1'b1, 32'h7, 32'h3, 2'b01, 0, "post_reset");
    transact(1'b0, '0, '0, 2'b00, 1'b1, 32'h7, 32'h3, 2'b01, 1, "post_reset2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
